// File: rtl/regfile_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    // x0 is hardwired zero: anything aimed at index 0 is masked off.
    function automatic logic idx_nz(input int unsigned idx);
        return idx != 0;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Core <-> register file bundle: read ports, ALU write, long-latency issue/writeback, status.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wa_en;
    logic [AW-1:0]   wa_rd;
    logic [XLEN-1:0] wa_data;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ready;
    logic [CW-1:0]   pend_cnt;
    logic            err;

    modport master (
        output rs1, rs2, wa_en, wa_rd, wa_data, iss_en, iss_rd, wb_en, wb_rd, wb_data,
        input  rs1_val, rs2_val, rs1_busy, rs2_busy, iss_ready, ready, pend_cnt, err
    );

    modport slave (
        input  rs1, rs2, wa_en, wa_rd, wa_data, iss_en, iss_rd, wb_en, wb_rd, wb_data,
        output rs1_val, rs2_val, rs1_busy, rs2_busy, iss_ready, ready, pend_cnt, err
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: tracks in-flight long-latency destinations, their count,
// issue acceptance and the sticky protocol-error flag.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             wa_en,
    input  logic [AW-1:0]    wa_rd,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    output logic [NREGS-1:0] pending,
    output logic             iss_ready,
    output logic [CW-1:0]    pend_cnt,
    output logic             err
);

    logic             do_set;
    logic             do_clr;
    logic             err_evt;
    logic [NREGS-1:0] pending_nxt;
    logic [CW-1:0]    cnt_nxt;

    // Judged against the pending state before this cycle's writeback clear.
    assign iss_ready = run & ~pending[iss_rd];

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        pending_nxt = pending;
        cnt_nxt     = pend_cnt;
        do_set      = run & iss_en & iss_ready & idx_nz(32'(iss_rd));
        do_clr      = run & wb_en & pending[wb_rd];
        if (do_clr) pending_nxt[wb_rd] = 1'b0;
        if (do_set) pending_nxt[iss_rd] = 1'b1;
        if (do_set && !do_clr)      cnt_nxt = pend_cnt + CW'(1);
        else if (do_clr && !do_set) cnt_nxt = pend_cnt - CW'(1);

        // Orphan writeback, WAW from port A onto a pending reg, or A/B same-rd collision.
        err_evt = run & (
                    (wb_en & idx_nz(32'(wb_rd)) & ~pending[wb_rd])
                  | (wa_en & idx_nz(32'(wa_rd)) & pending[wa_rd])
                  | (wa_en & wb_en & (wa_rd == wb_rd) & idx_nz(32'(wa_rd))));
    end

    // NOTE: sequential state is updated only with non-blocking '<=' so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
            err      <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= cnt_nxt;
            err      <= err | err_evt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// NREGS x XLEN register file, two read ports, ALU (A) and long-latency (B) write ports,
// post-reset clear sweep. Define REGFILE_SB_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);

    state_t           state;
    logic [AW-1:0]    clr_idx;
    logic             ready_q;
    logic             run;
    logic [NREGS-1:0] pending;
    logic [XLEN-1:0]  regs [NREGS];

    logic             wa_en;
    logic [AW-1:0]    wa_rd;
    logic [XLEN-1:0]  wa_data;
    logic             wb_en;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_data;

    assign wa_en   = bus.wa_en;
    assign wa_rd   = bus.wa_rd;
    assign wa_data = bus.wa_data;
    assign wb_en   = bus.wb_en;
    assign wb_rd   = bus.wb_rd;
    assign wb_data = bus.wb_data;

    assign run       = (state == RUN);
    assign bus.ready = ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + AW'(1);
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN:     ready_q <= 1'b1;
                default: state   <= CLEAR;
            endcase
        end
    end

    // NOTE: the array deliberately has no reset; the CLEAR sweep zeroes one entry per
    // cycle so the storage can map onto plain flops or RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[clr_idx] <= '0;
        end else begin
            // Port B owns the entry when both ports target it in the same cycle.
            if (wa_en && idx_nz(32'(wa_rd)) && !(wb_en && wb_rd == wa_rd))
                regs[wa_rd] <= wa_data;
            if (wb_en && idx_nz(32'(wb_rd)))
                regs[wb_rd] <= wb_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        if (run && idx_nz(32'(idx))) begin
`ifdef REGFILE_SB_BYPASS_EN
            if (wb_en && wb_rd == idx)      val = wb_data;
            else if (wa_en && wa_rd == idx) val = wa_data;
            else                            val = regs[idx];
`else
            val = regs[idx];
`endif
        end
        return val;
    endfunction

    function automatic logic busy_of(input logic [AW-1:0] idx);
        logic b;
        b = run && idx_nz(32'(idx)) && pending[idx];
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_en && wb_rd == idx) b = 1'b0;
`endif
        return b;
    endfunction

    always_comb bus.rs1_val  = read_port(bus.rs1);
    always_comb bus.rs2_val  = read_port(bus.rs2);
    always_comb bus.rs1_busy = busy_of(bus.rs1);
    always_comb bus.rs2_busy = busy_of(bus.rs2);

    regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .iss_en    (bus.iss_en),
        .iss_rd    (bus.iss_rd),
        .wa_en     (wa_en),
        .wa_rd     (wa_rd),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .pending   (pending),
        .iss_ready (bus.iss_ready),
        .pend_cnt  (bus.pend_cnt),
        .err       (bus.err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scenario bench for regfile_sb: writes push expected contents to a scoreboard queue,
// read-backs pop and compare.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef struct {
        string           name;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t            exp_q [$];
    logic [XLEN-1:0] model [NREGS];
    int              checks   = 0;
    int              failures = 0;

    task automatic idle();
        bus.wa_en  = 1'b0;
        bus.iss_en = 1'b0;
        bus.wb_en  = 1'b0;
    endtask

    task automatic push_write(input string name, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        model[rd] = (rd == '0) ? '0 : data;
        exp_q.push_back('{name, rd, model[rd]});
    endtask

    // Holds every write/issue input active through CLEAR to show they are ignored.
    task automatic sweep(input string tag);
        int low = 0;
        bit bad = 1'b0;
        bus.wa_en = 1'b1;  bus.wa_rd  = 5'd5; bus.wa_data = 32'hDEAD_BEEF;
        bus.iss_en = 1'b1; bus.iss_rd = 5'd6;
        bus.wb_en = 1'b1;  bus.wb_rd  = 5'd6; bus.wb_data = 32'hCAFE_F00D;
        bus.rs1 = 5'd5;    bus.rs2 = 5'd6;
        #1;
        while (bus.ready !== 1'b1 && low < 100) begin
            if (bus.rs1_val !== '0 || bus.rs2_val !== '0 || bus.rs1_busy !== 1'b0 ||
                bus.rs2_busy !== 1'b0 || bus.iss_ready !== 1'b0 || bus.err !== 1'b0 ||
                bus.pend_cnt !== '0)
                bad = 1'b1;
            low++;
            @(negedge clk); #1;
        end
        idle();
        checks++;
        if (low != 32) begin
            failures++;
            $display("FAIL %s_len: ready low for %0d cycles, expected 32", tag, low);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_outputs: CLEAR outputs not quiet, expected all zero", tag);
        end
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        @(negedge clk); #1;
        checks++;
        if (bus.rs1_val !== '0 || bus.rs2_val !== '0) begin
            failures++;
            $display("FAIL %s_cleared: x5=%h x6=%h expected 0", tag, bus.rs1_val, bus.rs2_val);
        end
        checks++;
        if (bus.pend_cnt !== '0 || bus.err !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_status: pend_cnt=%0d err=%b busy=%b expected 0 0 0",
                     tag, bus.pend_cnt, bus.err, bus.rs2_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.rs1 = 5'd5; bus.rs2 = '0;
        bus.wa_rd = '0; bus.wa_data = '0; bus.iss_rd = '0; bus.wb_rd = '0; bus.wb_data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b expected 0", bus.ready);
        end
        checks++;
        if (bus.pend_cnt !== '0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: pend_cnt=%0d err=%b expected 0 0", bus.pend_cnt, bus.err);
        end
        @(negedge clk);
        rst = 1'b0;
        sweep("sweep_initial");
    endtask

    task automatic test_write_read();
        exp_t e;
        @(negedge clk);
        bus.wa_en = 1'b1; bus.wa_rd = 5'd5; bus.wa_data = 32'h1F;
        push_write("wa_x5", 5'd5, 32'h1F);
        @(negedge clk);
        bus.wa_rd = '0; bus.wa_data = 32'hFF;
        push_write("wa_x0", '0, 32'hFF);
        for (int i = 0; i < 6; i++) begin
            logic [XLEN-1:0] d;
            @(negedge clk);
            d = $urandom;
            bus.wa_rd = AW'(8 + i); bus.wa_data = d;
            push_write($sformatf("wa_x%0d", 8 + i), AW'(8 + i), d);
        end
        @(negedge clk);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.rs1 = e.rd; bus.rs2 = e.rd;
            #1;
            checks++;
            if (bus.rs1_val !== e.data || bus.rs2_val !== e.data) begin
                failures++;
                $display("FAIL %s: rs1=%h rs2=%h expected %h", e.name, bus.rs1_val, bus.rs2_val, e.data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_issue_wb();
        exp_t e;
        @(negedge clk);
        bus.iss_en = 1'b1; bus.iss_rd = 5'd3; bus.rs1 = 5'd3;
        #1;
        checks++;
        if (bus.iss_ready !== 1'b1) begin
            failures++; $display("FAIL iss_ready_free: got %b expected 1", bus.iss_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.rs1_busy !== 1'b1 || bus.pend_cnt !== 6'd1) begin
            failures++;
            $display("FAIL iss_set: busy=%b pend_cnt=%0d expected 1 1", bus.rs1_busy, bus.pend_cnt);
        end
        checks++;
        if (bus.iss_ready !== 1'b0) begin
            failures++; $display("FAIL iss_ready_pending: got %b expected 0", bus.iss_ready);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.pend_cnt !== 6'd1 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL iss_rejected: pend_cnt=%0d err=%b expected 1 0", bus.pend_cnt, bus.err);
        end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hBA;
        push_write("wb_x3", 5'd3, 32'hBA);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        bus.rs1 = e.rd;
        #1;
        checks++;
        if (bus.rs1_val !== e.data || bus.rs1_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: val=%h busy=%b expected %h 0", e.name, bus.rs1_val, bus.rs1_busy, e.data);
        end
        checks++;
        if (bus.pend_cnt !== '0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL wb_cleared: pend_cnt=%0d err=%b expected 0 0", bus.pend_cnt, bus.err);
        end
    endtask

    task automatic test_hazards();
        exp_t e;
        @(negedge clk);
        bus.iss_en = 1'b1; bus.iss_rd = 5'd4;
        @(negedge clk);
        bus.iss_rd = 5'd7;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h4444_0004;
        push_write("wb_x4_with_iss7", 5'd4, 32'h4444_0004);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        bus.rs1 = e.rd; bus.rs2 = 5'd7;
        #1;
        checks++;
        if (bus.rs1_val !== e.data || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s: x4=%h busy4=%b busy7=%b expected %h 0 1",
                     e.name, bus.rs1_val, bus.rs1_busy, bus.rs2_busy, e.data);
        end
        checks++;
        if (bus.pend_cnt !== 6'd1 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL swap_pending: pend_cnt=%0d err=%b expected 1 0", bus.pend_cnt, bus.err);
        end
        bus.wa_en = 1'b1; bus.wa_rd = 5'd7; bus.wa_data = 32'h77;
        push_write("wa_x7_waw", 5'd7, 32'h77);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        bus.rs1 = e.rd;
        #1;
        checks++;
        if (bus.err !== 1'b1 || bus.rs1_val !== e.data) begin
            failures++;
            $display("FAIL %s: err=%b val=%h expected 1 %h", e.name, bus.err, bus.rs1_val, e.data);
        end
        bus.wa_en = 1'b1; bus.wa_rd = 5'd9; bus.wa_data = 32'h111;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h222;
        push_write("ab_collide_x9", 5'd9, 32'h222);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        bus.rs1 = e.rd;
        #1;
        checks++;
        if (bus.rs1_val !== e.data) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, bus.rs1_val, e.data);
        end
        bus.iss_en = 1'b1; bus.iss_rd = 5'd11;
        bus.wb_en = 1'b1;  bus.wb_rd = 5'd11; bus.wb_data = 32'h1111;
        push_write("iss_wb_x11", 5'd11, 32'h1111);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        bus.rs2 = e.rd;
        #1;
        checks++;
        if (bus.rs2_val !== e.data || bus.rs2_busy !== 1'b1 || bus.pend_cnt !== 6'd2) begin
            failures++;
            $display("FAIL %s: val=%h busy=%b pend_cnt=%0d expected %h 1 2",
                     e.name, bus.rs2_val, bus.rs2_busy, bus.pend_cnt, e.data);
        end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h7777;
        push_write("wb_x7", 5'd7, 32'h7777);
        @(negedge clk);
        bus.wb_rd = 5'd11; bus.wb_data = 32'hBBBB;
        push_write("wb_x11", 5'd11, 32'hBBBB);
        e = exp_q.pop_front();
        bus.rs1 = e.rd;
        #1;
        checks++;
        if (bus.rs1_val !== e.data || bus.pend_cnt !== 6'd1) begin
            failures++;
            $display("FAIL %s: val=%h pend_cnt=%0d expected %h 1", e.name, bus.rs1_val, bus.pend_cnt, e.data);
        end
        @(negedge clk);
        bus.wb_rd = '0; bus.wb_data = 32'hFFFF;
        push_write("wb_x0", '0, 32'hFFFF);
        e = exp_q.pop_front();
        bus.rs1 = e.rd;
        #1;
        checks++;
        if (bus.rs1_val !== e.data || bus.pend_cnt !== '0) begin
            failures++;
            $display("FAIL %s: val=%h pend_cnt=%0d expected %h 0", e.name, bus.rs1_val, bus.pend_cnt, e.data);
        end
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        bus.rs1 = e.rd;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (bus.rs1_val !== e.data || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL %s_sticky: x0=%h err=%b expected %h 1", e.name, bus.rs1_val, bus.err, e.data);
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [XLEN-1:0] old_val;
        @(negedge clk);
        bus.iss_en = 1'b1; bus.iss_rd = 5'd10;
        @(negedge clk);
        idle();
        old_val = model[10];
        bus.rs2 = 5'd10;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd10; bus.wb_data = 32'h4000_1100;
        #1;
        checks++;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.rs2_val !== 32'h4000_1100 || bus.rs2_busy !== 1'b0) begin
            failures++;
            $display("FAIL bypass_same_cycle: val=%h busy=%b expected 40001100 0", bus.rs2_val, bus.rs2_busy);
        end
`else
        if (bus.rs2_val !== old_val || bus.rs2_busy !== 1'b1) begin
            failures++;
            $display("FAIL no_bypass_same_cycle: val=%h busy=%b expected %h 1", bus.rs2_val, bus.rs2_busy, old_val);
        end
`endif
        push_write("wb_x10", 5'd10, 32'h4000_1100);
        @(negedge clk);
        idle();
        e = exp_q.pop_front();
        #1;
        checks++;
        if (bus.rs2_val !== e.data || bus.rs2_busy !== 1'b0 || bus.pend_cnt !== '0) begin
            failures++;
            $display("FAIL %s: val=%h busy=%b pend_cnt=%0d expected %h 0 0",
                     e.name, bus.rs2_val, bus.rs2_busy, bus.pend_cnt, e.data);
        end
    endtask

    task automatic test_reset_pending();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.iss_en = 1'b1; bus.iss_rd = AW'(i);
        end
        @(negedge clk);
        idle();
        bus.rs1 = 5'd5;
        #1;
        checks++;
        if (bus.pend_cnt !== 6'd3 || bus.rs1_val !== model[5]) begin
            failures++;
            $display("FAIL pre_reset: pend_cnt=%0d x5=%h expected 3 %h", bus.pend_cnt, bus.rs1_val, model[5]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pend_cnt !== '0 || bus.err !== 1'b0 || bus.ready !== 1'b0 || bus.rs1_val !== '0) begin
            failures++;
            $display("FAIL async_reset: pend_cnt=%0d err=%b ready=%b x5=%h expected 0 0 0 0",
                     bus.pend_cnt, bus.err, bus.ready, bus.rs1_val);
        end
        @(negedge clk);
        rst = 1'b0;
        sweep("sweep_after_pending");
    endtask

    task automatic test_mid_sweep();
        @(negedge clk);
        bus.wa_en = 1'b1; bus.wa_rd = 5'd20; bus.wa_data = 32'hABCD;
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++; $display("FAIL mid_sweep_ready: got %b expected 0", bus.ready);
        end
        @(negedge clk);
        rst = 1'b0;
        sweep("sweep_restart");
        bus.rs1 = 5'd20;
        #1;
        checks++;
        if (bus.rs1_val !== '0) begin
            failures++; $display("FAIL restart_x20: got %h expected 0", bus.rs1_val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_issue_wb();
        test_hazards();
        test_bypass();
        test_reset_pending();
        test_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the integer register file: NREGS x XLEN storage with two combinational read ports.
- Two write ports:
  - port A for single-cycle ALU results.
  - port B for long-latency MUL/DIV/REM writeback.
- A per-register pending scoreboard lets the core stall on RAW/WAW hazards against in-flight multi-cycle ops.
- After reset, a sequential clear sweep zeroes the array; no initial-block preload.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >= 4); register 0 is hardwired zero.
- AW, $clog2(NREGS), register index width.
- CW, $clog2(NREGS+1), pending-count width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1  in  AW  read port 1 index.
- rs2  in  AW  read port 2 index.
- rs1_val  out  XLEN  read port 1 data.
- rs2_val  out  XLEN  read port 2 data.
- rs1_busy  out  1  rs1 has a pending long-latency write.
- rs2_busy  out  1  rs2 has a pending long-latency write.
- wa_en  in  1  port A write enable.
- wa_rd  in  AW  port A destination index.
- wa_data  in  XLEN  port A write data.
- iss_en  in  1  long-latency op issue; marks iss_rd pending.
- iss_rd  in  AW  issue destination index.
- iss_ready  out  1  issue accepted this cycle.
- wb_en  in  1  port B writeback enable.
- wb_rd  in  AW  port B destination index.
- wb_data  in  XLEN  port B write data.
- ready  out  1  clear sweep done; block operational.
- pend_cnt  out  CW  number of registers currently pending.
- err  out  1  sticky protocol-error flag.

Behaviour:
- States: CLEAR, RUN.
  - rst asserted (any time, including mid-sweep or mid-operation) -> CLEAR; clr_idx=0, pending=0, pend_cnt=0, err=0, ready=0.
  - Array contents are not reset asynchronously.
  - CLEAR: one entry zeroed per cycle at clr_idx; clr_idx increments; at clr_idx==NREGS-1 (written that cycle) -> RUN next cycle.
  - Full sweep takes NREGS cycles after rst deassertion.
- CLEAR-state outputs:
  - rs1_val/rs2_val = 0, busy = 0, iss_ready = 0.
  - wa_en, wb_en and iss_en are ignored; no err is raised.
- RUN reads (combinational):
  - rsN_val = array[rsN], or 0 when rsN==0.
  - rsN_busy = pending[rsN] & (rsN!=0).
- Writes commit on the clock edge. Index 0 writes are dropped.
- iss_ready = RUN & ~pending[iss_rd], evaluated before this cycle's wb clear.
- Issue:
  - iss_en & iss_ready & iss_rd!=0 -> pending[iss_rd] set next cycle.
  - iss_rd==0 is accepted but sets nothing.
  - iss_en while ~iss_ready -> no state change; the core must hold.
- Writeback:
  - wb_en -> write wb_data, clear pending[wb_rd].
  - wb_en to a non-pending register -> write still occurs; err set.
- Same-cycle wb_en and iss_en on the same rd (pending): the wb clear and the new set both apply; pending stays 1. iss_ready stays 0, so this only occurs for a different rd.
- Port A vs pending:
  - wa_en to a pending register -> write performed; err set (WAW violation).
  - Same-cycle wa_en and wb_en to the same rd -> port B data wins; err set.
- pend_cnt tracks the number of set pending bits exactly (+1 on set, -1 on clear, net 0 on both). It saturates at neither end, since NREGS-1 is the maximum.
- Latency: a write is visible on a read port the cycle after the write edge (unless bypass is enabled).

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - A read index matching a same-cycle valid write (wb first, then wa; index != 0; RUN) returns the incoming data.
  - rsN_busy is deasserted when wb_en & wb_rd==rsN in that cycle.
- Undefined: reads return array contents only; busy drops the cycle after writeback.

Decomposition:
- Package regfile_sb_pkg:
  - state enum {CLEAR, RUN}.
  - Default XLEN/NREGS localparams.
  - Helper function for zero-index masking.
- One natural sub-module: regfile_sb_scoreboard.
  - Holds the pending vector, pend_cnt, iss_ready and err logic.
  - The top holds the array, clear FSM and read muxes.

Test Plan:
- Reset then release -> ready low for exactly 32 cycles; high on cycle 33; rs1=5 reads 0 throughout.
- RUN: wa_en wa_rd=5 wa_data=0x1F; next cycle rs1=5 -> 0x1F. wa_rd=0 data=0xFF -> rs2=0 reads 0.
- Issue and writeback:
  - iss_en iss_rd=3 -> rs1=3 busy=1, pend_cnt=1; second iss_en rd=3 -> iss_ready=0.
  - wb_en rd=3 data=0xBA -> busy=0 next cycle, rs1_val=0xBA, pend_cnt=0.
- Hazards:
  - Same-cycle wb rd=4 (pending) plus iss rd=7 -> pending {7}, pend_cnt=1, x4 written.
  - wa_en rd=7 while pending -> err=1 and sticky until rst.
- Assert rst mid-sweep at cycle 10 and with 3 regs pending -> pend_cnt=0, err=0, ready=0; full 32-cycle sweep restarts.
- With REGFILE_SB_BYPASS_EN: wb rd=10 data=0x40001100 with rs2=10 in the same cycle -> rs2_val=0x40001100, rs2_busy=0 combinationally. Without the macro: old value and busy=1 that cycle.
